// File: rtl/subsystem_axil_regs_pkg.sv
// -----------------------------------------------------------------------------
// subsystem_axil_pkg
//   Shared definitions for the subsystem AXI4-Lite register bank:
//   response codes, register byte offsets, write/read FSM state types and
//   the byte-strobe merge helper used when a write commits.
//   No ports (package).
// -----------------------------------------------------------------------------
package subsystem_axil_pkg;

  localparam int REG_W     = 32;
  localparam int STRB_W    = REG_W / 8;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  // Reserved for future decode errors; every address in this bank is mapped.
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0_OFF = 4'h0;
  localparam logic [3:0] REG1_OFF = 4'h4;
  localparam logic [3:0] REG2_OFF = 4'h8;
  localparam logic [3:0] REG3_OFF = 4'hC;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Byte k of the result comes from data when strb[k] is set, else from old.
  function automatic logic [REG_W-1:0] apply_wstrb(
    input logic [REG_W-1:0]  old,
    input logic [REG_W-1:0]  data,
    input logic [STRB_W-1:0] strb
  );
    logic [REG_W-1:0] merged;
    merged = old;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) merged[8*k +: 8] = data[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/subsystem_axil_regs_if.sv
// -----------------------------------------------------------------------------
// subsystem_axil_if
//   AXI4-Lite bus bundle for the S00_AXI port.
//   Signals: AW (AWADDR, AWPROT, AWVALID, AWREADY), W (WDATA, WSTRB, WVALID,
//   WREADY), B (BRESP, BVALID, BREADY), AR (ARADDR, ARPROT, ARVALID, ARREADY),
//   R (RDATA, RRESP, RVALID, RREADY).
//   Modports: master (drives requests) and slave (drives responses/readies).
// -----------------------------------------------------------------------------
interface subsystem_axil_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID,    input WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

endinterface

// File: rtl/subsystem_axil_regs.sv
// -----------------------------------------------------------------------------
// subsystem_axil_regs
//   AXI4-Lite slave holding four 32-bit RW control registers at offsets
//   0x0/0x4/0x8/0xC (address bits [1:0] ignored). One outstanding write and
//   one outstanding read; AW and W are accepted independently in any order.
//   All bus outputs come straight from flops.
// Ports:
//   ACLK     - clock, rising edge
//   ARESETN  - synchronous active-low reset
//   S00_AXI  - AXI4-Lite slave (subsystem_axil_if.slave)
//   regs_o   - live register contents {reg3, reg2, reg1, reg0}
// -----------------------------------------------------------------------------
module subsystem_axil_regs
  import subsystem_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  subsystem_axil_if.slave                   S00_AXI,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_o
);

  localparam int SEL_MSB = C_S_AXI_ADDR_WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write-side state
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [REG_IDX_W-1:0]  awidx_q, awidx_d;
  logic [REG_W-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;

  logic                  wr_commit;
  logic [REG_IDX_W-1:0]  commit_idx;
  logic [REG_W-1:0]      commit_data;
  logic [STRB_W-1:0]     commit_strb;

  // Read-side state
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [REG_W-1:0]      rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;

  assign aw_hs = S00_AXI.AWVALID && awready_q;
  assign w_hs  = S00_AXI.WVALID  && wready_q;
  assign ar_hs = S00_AXI.ARVALID && arready_q;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S00_AXI.AWPROT, S00_AXI.ARPROT,
                       S00_AXI.AWADDR[1:0], S00_AXI.ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write FSM: next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_state_d  = wr_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awidx_d     = awidx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    wr_commit   = 1'b0;
    commit_idx  = awidx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;

    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = S00_AXI.AWADDR[SEL_MSB -: REG_IDX_W];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S00_AXI.WDATA;
          wstrb_d  = S00_AXI.WSTRB;
        end
        // Both halves present (either held earlier or arriving now): commit
        // on this edge using the freshest values.
        if (aw_held_d && w_held_d) begin
          wr_commit   = 1'b1;
          commit_idx  = awidx_d;
          commit_data = wdata_d;
          commit_strb = wstrb_d;
          aw_held_d   = 1'b0;
          w_held_d    = 1'b0;
          awready_d   = 1'b0;
          wready_d    = 1'b0;
          bvalid_d    = 1'b1;
          wr_state_d  = W_RESP;
        end else begin
          // Also raises the readies on the first edge out of reset.
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (S00_AXI.BREADY) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          // regs_q still holds the pre-commit value if a write lands on the
          // same edge, so the read returns the old contents.
          rdata_d    = regs_q[S00_AXI.ARADDR[SEL_MSB -: REG_IDX_W]];
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S00_AXI.RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: the register array is reset like any control flop; it is four
  // words of software-visible state that must read 0 after reset, not a RAM.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[commit_idx] <= apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S00_AXI.AWREADY = awready_q;
  assign S00_AXI.WREADY  = wready_q;
  assign S00_AXI.BVALID  = bvalid_q;
  assign S00_AXI.BRESP   = AXI_RESP_OKAY;
  assign S00_AXI.ARREADY = arready_q;
  assign S00_AXI.RVALID  = rvalid_q;
  assign S00_AXI.RDATA   = rdata_q;
  assign S00_AXI.RRESP   = AXI_RESP_OKAY;

  assign regs_o = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_subsystem_axil_regs.sv
// -----------------------------------------------------------------------------
// tb_subsystem_axil_regs
//   Self-checking bench for subsystem_axil_regs. A plain array of four words
//   models the register bank; writes merge bytes by strobe, reads return the
//   model contents as they were before the capturing edge.
// -----------------------------------------------------------------------------
module tb_subsystem_axil_regs;

  logic         clk;
  logic         rst_n;
  logic [127:0] regs_o;

  subsystem_axil_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  subsystem_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .S00_AXI (axi),
    .regs_o  (regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [4];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  // Write with AW presented after aw_dly cycles and W after w_dly cycles.
  // Entered and left at a falling edge; BREADY is held at 1.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_fire, w_fire;
    int cyc = 0;
    axi.AWADDR = addr;
    axi.WDATA  = data;
    axi.WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      axi.AWVALID = !aw_done && (cyc >= aw_dly);
      axi.WVALID  = !w_done  && (cyc >= w_dly);
      aw_fire = axi.AWVALID && axi.AWREADY;
      w_fire  = axi.WVALID  && axi.WREADY;
      @(negedge clk);
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      if (aw_done && w_done) begin
        model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        check("wr_commit_regs", regs_o, model_flat());
        check("wr_bvalid", axi.BVALID, 1'b1);
        check("wr_bresp", axi.BRESP, 2'b00);
        check("wr_ready_low", {axi.AWREADY, axi.WREADY}, 2'b00);
      end else begin
        check("wr_pending_regs", regs_o, model_flat());
        check("wr_pending_bvalid", axi.BVALID, 1'b0);
        check("wr_pending_ready", {axi.AWREADY, axi.WREADY}, {!aw_done, !w_done});
      end
    end
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    if (!(aw_done && w_done)) check("wr_timeout", 1'b0, 1'b1);
    @(negedge clk);
    check("wr_bvalid_one_cycle", axi.BVALID, 1'b0);
    check("wr_ready_back", {axi.AWREADY, axi.WREADY}, 2'b11);
  endtask

  // Read with RREADY held low for hold cycles after RVALID rises.
  task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] rd);
    bit fired = 0;
    bit fire;
    logic [31:0] exp;
    int cyc = 0;
    rd = '0;
    #1;
    axi.ARADDR = addr;
    while (!fired && cyc < 40) begin
      axi.ARVALID = 1'b1;
      exp  = model[addr[3:2]];
      fire = axi.ARREADY;
      @(negedge clk);
      cyc++;
      if (fire) fired = 1;
      else #1;
    end
    axi.ARVALID = 1'b0;
    if (!fired) begin
      check("rd_timeout", 1'b0, 1'b1);
    end else begin
      rd = axi.RDATA;
      check("rd_rvalid", axi.RVALID, 1'b1);
      check("rd_data", axi.RDATA, exp);
      check("rd_rresp", axi.RRESP, 2'b00);
      check("rd_arready_low", axi.ARREADY, 1'b0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("rd_hold_rvalid", axi.RVALID, 1'b1);
        check("rd_hold_data", axi.RDATA, exp);
      end
      axi.RREADY = 1'b1;
      @(negedge clk);
      axi.RREADY = 1'b0;
      check("rd_rvalid_drop", axi.RVALID, 1'b0);
      check("rd_arready_back", axi.ARREADY, 1'b1);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("rst_regs", regs_o, 128'h0);
    check("rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b000);
    check("rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
    check("rst_rdata", axi.RDATA, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
  endtask

  logic [31:0] rd;

  initial begin
    rst_n       = 1'b0;
    axi.AWADDR  = '0;
    axi.AWPROT  = '0;
    axi.AWVALID = 1'b0;
    axi.WDATA   = '0;
    axi.WSTRB   = '0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b1;
    axi.ARADDR  = '0;
    axi.ARPROT  = '0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk);
    apply_reset();

    // Basic map: one word per register, then read all back.
    axi_write(4'h0, 32'h1, 4'hF, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0);
    for (int a = 0; a < 4; a++) begin
      axi_read(4'(a * 4), 0, rd);
      check("map_value", rd, 32'(a + 1));
    end
    check("map_regs_o", regs_o, 128'h00000004_00000003_00000002_00000001);

    // AW early, W four cycles later.
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 7);
    check("split_reg2", regs_o[95:64], 32'hDEADBEEF);
    // W before AW, with address low bits set (ignored).
    axi_write(4'h3, 32'hCAFEF00D, 4'hF, 4, 1);
    check("w_first_reg0", regs_o[31:0], 32'hCAFEF00D);

    // Byte strobes.
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(4'h4, 32'h12345678, 4'b0101, 0, 0);
    axi_read(4'h4, 0, rd);
    check("strb_0101", rd, 32'hFF34FF78);
    axi_write(4'h4, 32'h00000000, 4'b0000, 1, 0);
    axi_read(4'h5, 0, rd);
    check("strb_none", rd, 32'hFF34FF78);

    // Stalled read of reg3 while a write to reg3 commits.
    fork
      axi_read(4'hC, 5, rd);
      axi_write(4'hC, 32'hAAAA5555, 4'hF, 1, 1);
    join
    check("stall_old", rd, 32'h00000004);
    axi_read(4'hC, 0, rd);
    check("stall_new", rd, 32'hAAAA5555);

    // Same-edge write commit and read capture on reg1.
    fork
      axi_read(4'h4, 0, rd);
      axi_write(4'h4, 32'h0BADF00D, 4'hF, 0, 0);
    join
    check("same_edge_old", rd, 32'hFF34FF78);

    // Randomised traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  wa, ra;
      logic [31:0] wd;
      logic [3:0]  ws;
      wa = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3));
      axi_read(ra, $urandom_range(0, 2), rd);
    end

    // Reset while both a write response and read data are pending.
    axi.BREADY  = 1'b0;
    axi.AWADDR  = 4'h0;
    axi.WDATA   = 32'h55555555;
    axi.WSTRB   = 4'hF;
    axi.AWVALID = 1'b1;
    axi.WVALID  = 1'b1;
    axi.ARADDR  = 4'h8;
    axi.ARVALID = 1'b1;
    @(negedge clk);
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.ARVALID = 1'b0;
    model[0] = 32'h55555555;
    check("pre_rst_valids", {axi.BVALID, axi.RVALID}, 2'b11);
    check("pre_rst_reg0", regs_o[31:0], 32'h55555555);
    // A write presented during reset must not land.
    rst_n       = 1'b0;
    axi.AWVALID = 1'b1;
    axi.WVALID  = 1'b1;
    axi.AWADDR  = 4'h4;
    @(negedge clk);
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    check("mid_rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
    check("mid_rst_regs", regs_o, 128'h0);
    axi.BREADY = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("post_rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
    check("post_rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
    for (int a = 0; a < 4; a++) begin
      axi_read(4'(a * 4), 0, rd);
      check("post_rst_read", rd, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subsystem_axil_regs.md
# subsystem_axil_regs

AXI4-Lite slave register bank that terminates the subsystem's S00_AXI port. It is driven by the master agent or by the host interconnect. It holds four 32-bit read/write control registers and exposes their contents to the subsystem datapath. It supports one outstanding write and one outstanding read, with independent AW/W acceptance and byte strobes.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.

Ports:
- ACLK  in  1  single clock; every element samples on its rising edge.
- ARESETN  in  1  reset, synchronous and active-low.
- S00_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S00_AXI_AWPROT  in  3  ignored.
- S00_AXI_AWVALID / S00_AXI_AWREADY  in / out  1  write address handshake.
- S00_AXI_WDATA  in  32  write data.
- S00_AXI_WSTRB  in  4  byte enables.
- S00_AXI_WVALID / S00_AXI_WREADY  in / out  1  write data handshake.
- S00_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S00_AXI_BVALID / S00_AXI_BREADY  out / in  1  write response handshake.
- S00_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S00_AXI_ARPROT  in  3  ignored.
- S00_AXI_ARVALID / S00_AXI_ARREADY  in / out  1  read address handshake.
- S00_AXI_RDATA  out  32  read data.
- S00_AXI_RRESP  out  2  read response; always 2'b00.
- S00_AXI_RVALID / S00_AXI_RREADY  out / in  1  read data handshake.
- regs_o  out  128  live register contents {reg3, reg2, reg1, reg0}.

## Operation
- Register map: 0x0 reg0, 0x4 reg1, 0x8 reg2, 0xC reg3.
  - Address bits [1:0] are ignored.
  - All four registers are RW. No address is unmapped, so every response is OKAY.
- Reset: all registers are 0.
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are all 0. RDATA is 0.
  - Reset asserted mid-transaction discards any latched AW, W or AR and clears all VALIDs on that edge. No register update occurs on that edge.
- Write FSM, states W_IDLE → W_RESP:
  - In W_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - When both are held, the write commits and the FSM enters W_RESP with BVALID=1 and AWREADY=WREADY=0.
  - W_RESP → W_IDLE on BVALID && BREADY.
- Byte strobes: byte k of the selected register updates only when WSTRB[k]=1. WSTRB=0 leaves the register unchanged but still produces a response.
- Read FSM, states R_IDLE → R_DATA:
  - In R_IDLE, ARREADY=1. On the AR handshake, RDATA is loaded from the addressed register, then ARREADY=0 and RVALID=1.
  - R_DATA → R_IDLE on RVALID && RREADY.
  - RDATA stays stable while RVALID=1 && !RREADY.
- A write commit and a read capture on the same edge to the same register: the read returns the pre-write value.
- The read and write paths are fully independent; neither stalls the other.

## Timing
- READY signals go to 1 on the first rising edge at which ARESETN=1 is sampled.
- Write latency:
  - AW and W handshake together at edge N: the register and regs_o change at edge N, and BVALID=1 from edge N.
  - AW and W at edges N and M (M>N): the commit happens at M.
- Read latency: AR handshake at edge N gives RVALID=1 with data from edge N. Back-to-back reads therefore run at 1 per 2 cycles when RREADY is held at 1.
- Write throughput: 1 per 2 cycles when AW, W and BREADY are all held at 1.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package subsystem_axil_pkg holds:
  - AXI_RESP_OKAY, used by this block.
  - AXI_RESP_SLVERR, reserved and not used by this block.
  - Register offset constants REG0_OFF..REG3_OFF.
  - Enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- No sub-module. The strobe-merge function is a package function apply_wstrb(old, data, strb).

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four → RDATA 0x1..0x4, RRESP=0, and regs_o = 0x00000004_00000003_00000002_00000001.
- AW at cycle 3, W at cycle 7 (data 0xDEADBEEF to 0x8), BREADY=1 → reg2 unchanged until edge 7, BVALID high for exactly one cycle from edge 7.
- reg1=0xFFFFFFFF, write 0x12345678 with WSTRB=4'b0101 → read 0x4 returns 0xFF34FF78.
- Read 0xC with RREADY held at 0 for 5 cycles, while a write of 0xAAAA5555 to 0xC commits → RDATA stays at the old value throughout; a later read returns 0xAAAA5555.
- Assert ARESETN=0 while BVALID=1 and RVALID=1 → both drop on that edge, all registers read 0 after release, and READYs return 1 on the first released edge.
